// File: rtl/demux_1to2_reg.sv
// demux_1to2_reg: registered 1-to-2 demultiplexer for a valid/ready stream.
// Each beat goes to channel 0 or channel 1, as chosen by select_i. Each
// channel has a one-entry output slot, so no combinational path runs from
// data_i to data0_o/data1_o.
// Optional feature: define DEMUX_1TO2_CNT_EN to build the per-channel
// delivered-beat counters (cnt0_o/cnt1_o). Without the macro they are tied
// to zero and the port list is unchanged.
//
// Handshake rules (all channels): a beat transfers on a rising edge where
// valid && ready are both high. A producer holds valid and payload stable
// until that transfer happens. ready never depends on the same
// interface's valid. Here ready_o depends only on select_i and on the
// state and readiness of the selected slot.
module demux_1to2_reg #(
    parameter int size  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [size-1:0]  data_i,
    input  logic             select_i,
    output logic             valid0_o,
    input  logic             ready0_i,
    output logic [size-1:0]  data0_o,
    output logic             valid1_o,
    input  logic             ready1_i,
    output logic [size-1:0]  data1_o,
    output logic [CNT_W-1:0] cnt0_o,
    output logic [CNT_W-1:0] cnt1_o
);

    // Per-channel slot state. The slot state is visible on valid0_o/valid1_o.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    slot_state_t state0_q, state0_d;
    slot_state_t state1_q, state1_d;
    logic [size-1:0] data0_q, data0_d;
    logic [size-1:0] data1_q, data1_d;

    logic load0, load1;
    logic drain0, drain1;

    // Handshake decode: input acceptance is gated by the selected slot only.
    always_comb begin
        valid0_o = (state0_q == SLOT_FULL);
        valid1_o = (state1_q == SLOT_FULL);
        drain0   = valid0_o && ready0_i;
        drain1   = valid1_o && ready1_i;
        if (select_i) begin
            ready_o = !valid1_o || ready1_i;
        end else begin
            ready_o = !valid0_o || ready0_i;
        end
        load0 = valid_i && ready_o && !select_i;
        load1 = valid_i && ready_o &&  select_i;
    end

    // Slot next-state: a load wins over a drain, so a slot stays FULL when it drains and reloads in one cycle.
    always_comb begin
        state0_d = state0_q;
        state1_d = state1_q;
        data0_d  = data0_q;
        data1_d  = data1_q;
        if (load0) begin
            state0_d = SLOT_FULL;
            data0_d  = data_i;
        end else if (drain0) begin
            state0_d = SLOT_EMPTY;
        end
        if (load1) begin
            state1_d = SLOT_FULL;
            data1_d  = data_i;
        end else if (drain1) begin
            state1_d = SLOT_EMPTY;
        end
    end

    // Slot registers; reset discards any held beat and clears the payloads.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state0_q <= SLOT_EMPTY;
            state1_q <= SLOT_EMPTY;
            data0_q  <= '0;
            data1_q  <= '0;
        end else begin
            state0_q <= state0_d;
            state1_q <= state1_d;
            data0_q  <= data0_d;
            data1_q  <= data1_d;
        end
    end

    assign data0_o = data0_q;
    assign data1_o = data1_q;

`ifdef DEMUX_1TO2_CNT_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    // Delivered-beat counters: count output handshakes and wrap modulo 2^CNT_W.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (drain0) begin
            cnt0_d = cnt0_q + CNT_W'(1);
        end
        if (drain1) begin
            cnt1_d = cnt1_q + CNT_W'(1);
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0_o = cnt0_q;
    assign cnt1_o = cnt1_q;
`else
    assign cnt0_o = '0;
    assign cnt1_o = '0;
`endif

endmodule

// File: tb/tb_demux_1to2_reg.sv
// Bench for demux_1to2_reg. A queue-per-channel model predicts the slot
// contents, ready_o and the delivered counts. Directed scenarios also check
// literal values.
module tb_demux_1to2_reg;
  localparam int W     = 32;
  localparam int CNT_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_i    = 1'b1;
  logic             valid_i  = 1'b0;
  logic             ready_o;
  logic [W-1:0]     data_i   = '0;
  logic             select_i = 1'b0;
  logic             valid0_o;
  logic             ready0_i = 1'b1;
  logic [W-1:0]     data0_o;
  logic             valid1_o;
  logic             ready1_i = 1'b1;
  logic [W-1:0]     data1_o;
  logic [CNT_W-1:0] cnt0_o;
  logic [CNT_W-1:0] cnt1_o;

  demux_1to2_reg #(.size(W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i), .select_i(select_i),
    .valid0_o(valid0_o), .ready0_i(ready0_i), .data0_o(data0_o),
    .valid1_o(valid1_o), .ready1_i(ready1_i), .data1_o(data1_o),
    .cnt0_o(cnt0_o), .cnt1_o(cnt1_o)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int passes = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model / scoreboard ----------------
  // Each slot is a queue holding at most one beat, and the head is what the
  // channel presents. Counts are plain integers that are reduced modulo
  // 2^CNT_W when compared.
  logic [W-1:0] exp0_q[$];
  logic [W-1:0] exp1_q[$];
  int cnt0_m = 0;
  int cnt1_m = 0;
  bit m_acc;

  function automatic bit model_ready();
    if (select_i) return (exp1_q.size() == 0) || ready1_i;
    return (exp0_q.size() == 0) || ready0_i;
  endfunction

  always @(posedge clk) begin
    if (rst_i) begin
      exp0_q.delete();
      exp1_q.delete();
      cnt0_m = 0;
      cnt1_m = 0;
    end else begin
      m_acc = valid_i && model_ready();
      if (exp0_q.size() != 0 && ready0_i) begin void'(exp0_q.pop_front()); cnt0_m++; end
      if (exp1_q.size() != 0 && ready1_i) begin void'(exp1_q.pop_front()); cnt1_m++; end
      if (m_acc) begin
        if (select_i) exp1_q.push_back(data_i);
        else          exp0_q.push_back(data_i);
      end
    end
  end

  function automatic logic [63:0] exp_cnt(input int n);
`ifdef DEMUX_1TO2_CNT_EN
    return 64'(n % (1 << CNT_W));
`else
    return 64'(n - n);
`endif
  endfunction

  // Compare process: every cycle, half a period after the edge.
  always @(negedge clk) begin
    if (check_en) begin
      check("valid0", 64'(valid0_o), 64'(exp0_q.size() != 0));
      check("valid1", 64'(valid1_o), 64'(exp1_q.size() != 0));
      check("ready_o", 64'(ready_o), 64'(model_ready()));
      if (exp0_q.size() != 0) check("data0", 64'(data0_o), 64'(exp0_q[0]));
      if (exp1_q.size() != 0) check("data1", 64'(data1_o), 64'(exp1_q[0]));
      check("cnt0", 64'(cnt0_o), exp_cnt(cnt0_m));
      check("cnt1", 64'(cnt1_o), exp_cnt(cnt1_m));
    end
  end

  // Source obligation: an offered but unaccepted beat must stay unchanged.
  bit           pend = 1'b0;
  logic [W-1:0] pend_d;
  logic         pend_s;
  always @(negedge clk) begin
    if (pend && !rst_i) begin
      check("src_hold_valid", 64'(valid_i), 64'(1));
      check("src_hold_data", 64'(data_i), 64'(pend_d));
      check("src_hold_sel", 64'(select_i), 64'(pend_s));
    end
    pend   = valid_i && (ready_o !== 1'b1) && !rst_i;
    pend_d = data_i;
    pend_s = select_i;
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [W-1:0] d, input logic s,
                       input logic r0, input logic r1);
    valid_i = v; data_i = d; select_i = s; ready0_i = r0; ready1_i = r1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- directed + randomised stimulus ----------------
  initial begin
    bit acc;
    // Reset for two cycles while a beat is offered.
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1);
    rst_i = 1'b1;
    next_cycle();
    check_en = 1'b1;
    next_cycle();
    rst_i = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("rst_valid0", 64'(valid0_o), 64'(0));
    check("rst_valid1", 64'(valid1_o), 64'(0));
    check("rst_data0", 64'(data0_o), 64'(0));
    check("rst_data1", 64'(data1_o), 64'(0));
    check("rst_ready", 64'(ready_o), 64'(1));

    // Basic routing.
    next_cycle();
    drive(1'b1, 32'hA5A5_0001, 1'b0, 1'b1, 1'b1);
    next_cycle();
    drive(1'b1, 32'h0000_BEEF, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    check("route_v0", 64'(valid0_o), 64'(1));
    check("route_d0", 64'(data0_o), 64'h0000_0000_A5A5_0001);
    next_cycle();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("route_v0_once", 64'(valid0_o), 64'(0));
    check("route_v1", 64'(valid1_o), 64'(1));
    check("route_d1", 64'(data1_o), 64'h0000_0000_0000_BEEF);
    next_cycle();
    @(negedge clk);
    check("route_v1_once", 64'(valid1_o), 64'(0));

    // Full throughput: beats 1..8 back to back on channel 0.
    for (int i = 1; i <= 8; i++) begin
      next_cycle();
      drive(1'b1, W'(i), 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      check("tput_ready", 64'(ready_o), 64'(1));
      if (i > 1) check("tput_data0", 64'(data0_o), 64'(i - 1));
    end
    next_cycle();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("tput_last", 64'(data0_o), 64'(8));

    // Backpressure and isolation.
    next_cycle();
    drive(1'b1, 32'h11, 1'b0, 1'b0, 1'b1);
    next_cycle();
    drive(1'b1, 32'h22, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_ready", 64'(ready_o), 64'(0));
      check("bp_data0", 64'(data0_o), 64'h11);
      next_cycle();
    end
    drive(1'b1, 32'h22, 1'b0, 1'b1, 1'b1);
    next_cycle();
    drive(1'b1, 32'h33, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("iso_d0", 64'(data0_o), 64'h22);
    check("iso_ready", 64'(ready_o), 64'(1));
    next_cycle();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("iso_v1", 64'(valid1_o), 64'(1));
    check("iso_d1", 64'(data1_o), 64'h33);
    check("iso_v0_held", 64'(valid0_o), 64'(1));

    // Reset mid-operation with both slots full and stalled.
    next_cycle();
    rst_i = 1'b1;
    next_cycle();
    rst_i = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_v0", 64'(valid0_o), 64'(0));
      check("mid_rst_v1", 64'(valid1_o), 64'(0));
      next_cycle();
    end

    // 17 beats on channel 1: the 4-bit counter wraps to 1.
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, W'(32'h100 + i), 1'b1, 1'b1, 1'b1);
      next_cycle();
    end
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
    next_cycle();
    @(negedge clk);
`ifdef DEMUX_1TO2_CNT_EN
    check("cnt1_wrap", 64'(cnt1_o), 64'(1));
`else
    check("cnt1_off", 64'(cnt1_o), 64'(0));
`endif
    check("cnt0_zero", 64'(cnt0_o), 64'(0));

    // Randomised phase: random consumers, with the source holding each beat until it is accepted.
    next_cycle();
    drive(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      acc = valid_i && ready_o;
      next_cycle();
      ready0_i = 1'($urandom_range(0, 3) != 0);
      ready1_i = 1'($urandom_range(0, 2) != 0);
      if (acc || !valid_i) begin
        valid_i  = 1'($urandom_range(0, 3) != 0);
        data_i   = W'($urandom);
        select_i = 1'($urandom_range(0, 1));
      end
    end
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
    next_cycle();
    next_cycle();
    @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
